// File: rtl/lifo_arb_pkg.sv
// rtl/lifo_arb_pkg.sv - shared FSM states, op encodings and index-width helper for lifo_arbiter
package lifo_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_EXEC    = 2'd1;
  localparam state_t ST_POPWAIT = 2'd2;
  localparam state_t ST_RESP    = 2'd3;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  // Width of a requester index; never below 1 so vectors stay legal.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker; the pointer register lives in the parent
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  int   w_cand;
  logic w_found;

  // Scan from the farthest offset back to the pointer so the nearest set bit wins.
  always_comb begin
    w_cand  = 0;
    w_found = 1'b0;
    o_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_cand = (int'(i_ptr) + i) % NREQ;
      if (i_req[w_cand]) begin
        o_idx   = IW'(w_cand);
        w_found = 1'b1;
      end
    end
  end

  assign o_any = w_found;
  assign o_gnt = (i_en && w_found) ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/lifo_arbiter.sv
// rtl/lifo_arbiter.sv - round-robin, one-op-at-a-time front end guarding a shared single-port LIFO
module lifo_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  lifo_push,
  output logic                  lifo_pop,
  output logic [WIDTH-1:0]      lifo_din,
  input  logic [WIDTH-1:0]      lifo_dout,
  input  logic                  lifo_empty,
  input  logic                  lifo_full
);

  localparam int IW = idx_width(NREQ);

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_win;
  logic             r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_err;

  logic [NREQ-1:0]  w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic             w_idle;
  logic             w_exec;
  logic             w_illegal;
  logic [NREQ-1:0]  w_win_onehot;

  assign w_idle       = rstn && (r_state == ST_IDLE);
  assign w_exec       = rstn && (r_state == ST_EXEC);
  assign w_illegal    = (r_op == OP_PUSH) ? lifo_full : lifo_empty;
  assign w_win_onehot = NREQ'(1) << r_win;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_idle),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Accept is only visible while idle; strobes fire only in EXEC and only for legal ops.
  assign req_ready = w_gnt;
  assign lifo_push = w_exec && (r_op == OP_PUSH) && !w_illegal;
  assign lifo_pop  = w_exec && (r_op == OP_POP)  && !w_illegal;
  assign lifo_din  = lifo_push ? r_data : '0;
  assign rsp_valid = (rstn && (r_state == ST_RESP)) ? w_win_onehot : '0;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_err;

  // Serialising FSM: latch winner, issue one strobe, collect pop data, respond.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_win      <= '0;
      r_op       <= OP_POP;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_win   <= w_idx;
            r_op    <= req_op[w_idx];
            r_data  <= req_data[w_idx*WIDTH +: WIDTH];
            r_ptr   <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_illegal) begin
            r_err      <= 1'b1;
            r_rsp_data <= '0;
            r_state    <= ST_RESP;
          end else if (r_op == OP_PUSH) begin
            r_err      <= 1'b0;
            r_rsp_data <= '0;
            r_state    <= ST_RESP;
          end else begin
            r_state    <= ST_POPWAIT;
          end
        end
        ST_POPWAIT: begin
          r_rsp_data <= lifo_dout;
          r_err      <= 1'b0;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
